// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared types and constants for the instruction-fetch front end
package if_fetch_stage_pkg;
  localparam int INST_W = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/if_fetch_stage_inst_fifo.sv
// if_fetch_stage_inst_fifo: small synchronous FIFO of {pc, inst} entries with flush
module if_fetch_stage_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign head = mem_q[rd_q];
  assign do_pop = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  // pointers and occupancy; flush wins over any push or pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage; a push into a full FIFO overwrites the slot being popped
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch PC owner, single-outstanding memory requester and decode-side buffer
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d;
  logic push, pop, full, empty, room_after_push;
  logic [CW-1:0] count;
  logic [2*INST_W-1:0] head;
  assign pop = !empty && id_ready;
  assign push = state_q == WAIT && inst_rvalid && !redirect;
  assign room_after_push = pop || count < CW'(FIFO_DEPTH - 1);
  assign inst_req = state_q == REQ;
  assign inst_addr = fetch_pc_q;
  assign id_valid = !empty;
  assign id_inst = empty ? '0 : head[INST_W-1:0];
  assign id_pc = empty ? '0 : head[2*INST_W-1:INST_W];
  if_fetch_stage_inst_fifo #(.DEPTH(FIFO_DEPTH), .W(2*INST_W)) u_inst_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({pend_pc_q, inst_rdata}),
    .pop(pop),
    .flush(redirect),
    .full(full),
    .empty(empty),
    .count(count),
    .head(head)
  );
  // next state and PCs; a redirect overrides the normal flow and decides whether a response is still owed
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      IDLE: if (!full) state_d = REQ;
      REQ: if (inst_gnt) begin
        state_d = WAIT;
        pend_pc_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      WAIT: if (inst_rvalid) state_d = room_after_push ? REQ : IDLE;
      DROP: if (inst_rvalid) state_d = REQ;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      state_d = ((state_q == REQ && inst_gnt) || ((state_q == WAIT || state_q == DROP) && !inst_rvalid)) ? DROP : REQ;
    end
  end
  // state and PC registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scoreboard bench for the fetch stage
module tb_if_fetch_stage;
  logic clk = 0;
  logic rst = 0;
  logic inst_req, inst_gnt, inst_rvalid, redirect, id_valid, id_ready;
  logic [31:0] inst_addr, inst_rdata, redirect_pc, id_inst, id_pc;
  logic [63:0] sb[$];
  int total = 0;
  int bad = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'h0101_0101;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [63:0] e;
    if (id_valid && id_ready) begin
      if (sb.size() == 0) chk("unexpected_pop", id_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("id_pc", id_pc, e[63:32]);
        chk("id_inst", id_inst, e[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [31:0] a, input bit keep);
    int n = 0;
    while (!inst_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", inst_req, 1'b1);
    chk("req_addr", inst_addr, a);
    inst_gnt = 1;
    tick();
    inst_gnt = 0;
    inst_rvalid = 1;
    inst_rdata = dat(a);
    if (keep) sb.push_back({a, dat(a)});
    tick();
    inst_rvalid = 0;
    inst_rdata = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    inst_gnt = 0; inst_rvalid = 0; inst_rdata = 0;
    redirect = 0; redirect_pc = 0; id_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req", inst_req, 1'b0);
    chk("rst_addr", inst_addr, 32'hBFC0_0000);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    rst = 1;
    // streaming with zero-wait memory
    serve(32'hBFC0_0000, 1);
    chk("lat_valid", id_valid, 1'b1);
    chk("lat_req", inst_req, 1'b1);
    serve(32'hBFC0_0004, 1);
    chk("b2b_req", inst_req, 1'b1);
    serve(32'hBFC0_0008, 1);
    tick();
    // decode stall fills the buffer
    id_ready = 0;
    serve(32'hBFC0_000C, 1);
    serve(32'hBFC0_0010, 1);
    for (int i = 0; i < 4; i++) begin
      chk("full_noreq", inst_req, 1'b0);
      chk("full_valid", id_valid, 1'b1);
      chk("full_head", id_pc, 32'hBFC0_000C);
      tick();
    end
    id_ready = 1;
    tick();
    serve(32'hBFC0_0014, 1);
    // redirect while waiting, stale response later
    inst_gnt = 1;
    tick();
    inst_gnt = 0;
    redirect = 1;
    redirect_pc = 32'h8000_1003;
    tick();
    redirect = 0;
    chk("drop_req", inst_req, 1'b0);
    chk("drop_addr", inst_addr, 32'h8000_1000);
    chk("drop_valid", id_valid, 1'b0);
    tick();
    tick();
    inst_rvalid = 1;
    inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_rvalid = 0;
    inst_rdata = 0;
    chk("stale_valid", id_valid, 1'b0);
    chk("stale_req", inst_req, 1'b1);
    serve(32'h8000_1000, 1);
    chk("redir_head", id_pc, 32'h8000_1000);
    tick();
    // redirect coinciding with a response, one entry queued
    id_ready = 0;
    serve(32'h8000_1004, 0);
    chk("q1_valid", id_valid, 1'b1);
    inst_gnt = 1;
    tick();
    inst_gnt = 0;
    inst_rvalid = 1;
    inst_rdata = 32'h1111_2222;
    redirect = 1;
    redirect_pc = 32'h0000_2000;
    tick();
    inst_rvalid = 0;
    redirect = 0;
    chk("flush_valid", id_valid, 1'b0);
    chk("flush_req", inst_req, 1'b1);
    chk("flush_addr", inst_addr, 32'h0000_2000);
    id_ready = 1;
    serve(32'h0000_2000, 1);
    // ungranted request retargeted mid-stall
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", inst_req, 1'b1);
      chk("stall_addr", inst_addr, i <= 2 ? 32'h0000_2004 : 32'h0000_3000);
      redirect = (i == 2);
      redirect_pc = 32'h0000_3000;
      tick();
      redirect = 0;
    end
    serve(32'h0000_3000, 1);
    tick();
    // asynchronous reset in the middle of a wait
    id_ready = 0;
    serve(32'h0000_3004, 0);
    chk("pre_rst_valid", id_valid, 1'b1);
    inst_gnt = 1;
    tick();
    inst_gnt = 0;
    #2;
    rst = 0;
    #1;
    chk("arst_req", inst_req, 1'b0);
    chk("arst_addr", inst_addr, 32'hBFC0_0000);
    chk("arst_valid", id_valid, 1'b0);
    chk("arst_pc", id_pc, 32'h0);
    chk("arst_inst", id_inst, 32'h0);
    @(posedge clk); #1;
    rst = 1;
    id_ready = 1;
    inst_rvalid = 1;
    inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_rvalid = 0;
    inst_rdata = 0;
    chk("late_valid", id_valid, 1'b0);
    serve(32'hBFC0_0000, 1);
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
